// File: rtl/spi32_slave_pkg.sv
// Shared definitions for the SPI mode-0 responder: state encodings, word/byte widths
// and a helper that keeps only the low complete bytes of a received word.
package spi32_slave_pkg;

    typedef enum logic [1:0] {
        SPIS_WAIT_CS_HIGH = 2'd0,
        SPIS_IDLE         = 2'd1,
        SPIS_ACTIVE       = 2'd2
    } spis_state_t;

    localparam int WORD_BITS = 32;
    localparam int BYTE_BITS = 8;
    localparam int BIT_CNT_W = 5;

    // Zero everything above the lowest nb bytes (nb in 0..3).
    function automatic logic [WORD_BITS-1:0] keep_low_bytes(
        input logic [WORD_BITS-1:0] word,
        input logic [1:0]           nb
    );
        logic [WORD_BITS-1:0] mask;
        mask = ~({WORD_BITS{1'b1}} << {nb, 3'b000});
        return word & mask;
    endfunction

endpackage

// File: rtl/spi32_slave_sync.sv
// Multi-flop synchroniser for one asynchronous input; reset value selectable so
// an active-low select can power up deasserted.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_reg <= {STAGES{RESET_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi32_slave.sv
// SPI mode-0 responder: oversamples sclk/cs/sdi in the clk domain, assembles MSB-first
// 32-bit words from MOSI and shifts a preloaded 32-bit word out on MISO.
module spi32_slave
    import spi32_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BYTES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        load,
    output logic [31:0] dout,
    output logic        rx_valid,
    output logic [2:0]  nbytes,
    output logic        busy,
    output logic        frame_err,
    input  logic        sclk,
    input  logic        cs,
    input  logic        sdi,
    output logic        sdo
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(MAX_BYTES * BYTE_BITS - 1);
    localparam int                   SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

    logic [2:0] raw_in;
    logic [2:0] sync_out;

    assign raw_in = {sdi, cs, sclk};

    // Index 1 is cs, which must come out of reset deasserted (high).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_ff #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (gi == 1)
            ) u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (raw_in[gi]),
                .q     (sync_out[gi])
            );
        end
    endgenerate

    logic sclk_s, cs_s, sdi_s;
    assign sclk_s = sync_out[0];
    assign cs_s   = sync_out[1];
    assign sdi_s  = sync_out[2];

    logic sclk_d_reg, cs_d_reg;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_d_reg <= 1'b0;
            cs_d_reg   <= 1'b1;
        end else begin
            sclk_d_reg <= sclk_s;
            cs_d_reg   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign cs_rise   = cs_s & ~cs_d_reg;
    assign cs_fall   = ~cs_s & cs_d_reg;

    // The cs synchroniser resets to 1, so its output is not trustworthy until the
    // chain has refilled with real samples; only then may WAIT_CS_HIGH be left.
    logic [SETTLE_W-1:0] settle_reg;
    logic                settle_done;

    assign settle_done = (settle_reg == SETTLE_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_reg <= '0;
        end else if (!settle_done) begin
            settle_reg <= settle_reg + SETTLE_W'(1);
        end
    end

    spis_state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SPIS_WAIT_CS_HIGH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            SPIS_WAIT_CS_HIGH: if (settle_done && cs_s) state_next = SPIS_IDLE;
            SPIS_IDLE:         if (cs_fall)             state_next = SPIS_ACTIVE;
            SPIS_ACTIVE:       if (cs_rise)             state_next = SPIS_IDLE;
            default:                                    state_next = SPIS_WAIT_CS_HIGH;
        endcase
    end

    logic [31:0]          tx_buf_reg, tx_shift_reg, rx_shift_reg, dout_reg;
    logic [BIT_CNT_W-1:0] bitcnt_reg;
    logic [2:0]           nbytes_reg;
    logic                 rx_valid_reg, frame_err_reg;

    logic [31:0] tx_src, rx_next, rx_aligned;
    logic [1:0]  nb_done;

    assign tx_src     = load ? din : tx_buf_reg;
    assign rx_next    = {rx_shift_reg[30:0], sdi_s};
    assign nb_done    = bitcnt_reg[4:3];
    assign rx_aligned = keep_low_bytes(rx_shift_reg >> bitcnt_reg[2:0], nb_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_buf_reg    <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            bitcnt_reg    <= '0;
            dout_reg      <= '0;
            nbytes_reg    <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (load) begin
                tx_buf_reg <= din;
            end
            unique case (state_reg)
                SPIS_IDLE: begin
                    if (cs_fall) begin
                        tx_shift_reg <= tx_src;
                        rx_shift_reg <= '0;
                        bitcnt_reg   <= '0;
                    end
                end
                SPIS_ACTIVE: begin
                    if (cs_rise) begin
                        if (nb_done != 2'd0) begin
                            dout_reg     <= rx_aligned;
                            nbytes_reg   <= {1'b0, nb_done};
                            rx_valid_reg <= 1'b1;
                        end
                        frame_err_reg <= |bitcnt_reg[2:0];
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_reg <= rx_next;
                            bitcnt_reg   <= bitcnt_reg + BIT_CNT_W'(1);
                            if (bitcnt_reg == LAST_BIT) begin
                                dout_reg     <= rx_next;
                                nbytes_reg   <= 3'd4;
                                rx_valid_reg <= 1'b1;
                            end
                        end
                        // A falling edge with the counter at zero closes a full word.
                        if (sclk_fall) begin
                            if (bitcnt_reg == '0) begin
                                tx_shift_reg <= tx_src;
                            end else begin
                                tx_shift_reg <= {tx_shift_reg[30:0], 1'b0};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg == SPIS_ACTIVE);
    assign sdo       = busy & tx_shift_reg[31];
    assign dout      = dout_reg;
    assign nbytes    = nbytes_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi32_slave.sv
// Randomised SPI master stimulus against a bit-level model of frames, words and
// byte accounting; a negedge monitor checks every rx_valid/frame_err pulse.
module tb_spi32_slave;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset, load, sclk, cs, sdi;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rx_valid, busy, frame_err, sdo;
    logic [2:0]  nbytes;

    spi32_slave #(.SYNC_STAGES(2), .MAX_BYTES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .load      (load),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .nbytes    (nbytes),
        .busy      (busy),
        .frame_err (frame_err),
        .sclk      (sclk),
        .cs        (cs),
        .sdi       (sdi),
        .sdo       (sdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  nb;
    } rx_t;

    rx_t          exp_rx[$];
    int           exp_err = 0;
    int           tests = 0;
    int           fails = 0;
    int           rx_pulses = 0;
    int           err_pulses = 0;
    int           both_pulses = 0;
    int           cs_quiet = 0;
    logic [31:0]  last_dout = '0;
    logic [2:0]   last_nb = '0;
    logic [31:0]  model_buf = '0;
    logic [127:0] miso_cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_pulses++;
            last_dout = dout;
            last_nb   = nbytes;
            check("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
            if (exp_rx.size() > 0) begin
                rx_t e;
                e = exp_rx.pop_front();
                check("rx_dout", dout, e.d);
                check("rx_nbytes", 32'(nbytes), 32'(e.nb));
                $display("[TB] rx word %h nbytes %0d", dout, nbytes);
            end
        end
        if (frame_err === 1'b1) begin
            err_pulses++;
            if (rx_valid === 1'b1) both_pulses++;
            check("frame_err_expected", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0) exp_err--;
        end
        if (cs === 1'b1 && reset === 1'b0) cs_quiet++;
        else cs_quiet = 0;
        if (cs_quiet > 6) begin
            check("idle_sdo", 32'(sdo), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    end

    // load_at: -1 none, -2 coincident with detected cs fall, >=0 bit index.
    task automatic run_frame(input int nbits, input logic [127:0] mosi, input int load_at,
                             input logic [31:0] load_val, input int abort_at);
        logic [31:0] w0, w1, v;
        logic        exp_bit;
        int          base, rem, nb;
        w0 = (load_at == -2) ? load_val : model_buf;
        w1 = (load_at != -1) ? load_val : model_buf;
        if (abort_at < 0) begin
            for (int w = 0; w < nbits / 32; w++) begin
                v = '0;
                for (int j = 0; j < 32; j++) v = {v[30:0], mosi[127 - (w * 32 + j)]};
                exp_rx.push_back('{v, 3'd4});
            end
            base = (nbits / 32) * 32;
            rem  = nbits % 32;
            nb   = rem / 8;
            if (nb > 0) begin
                v = '0;
                for (int j = 0; j < nb * 8; j++) v = {v[30:0], mosi[127 - (base + j)]};
                exp_rx.push_back('{v, 3'(nb)});
            end
            if (rem % 8 != 0) exp_err++;
        end
        miso_cap = '0;
        @(negedge clk);
        cs = 1'b0;
        if (load_at == -2) begin
            wait_cycles(2);
            din = load_val;
            load = 1'b1;
            wait_cycles(1);
            load = 1'b0;
            model_buf = load_val;
            wait_cycles(HALF - 3);
        end else begin
            wait_cycles(HALF);
        end
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                wait_cycles(3);
                reset = 1'b0;
                model_buf = '0;
                return;
            end
            sdi = mosi[127 - i];
            if (i == load_at) begin
                din = load_val;
                load = 1'b1;
                wait_cycles(1);
                load = 1'b0;
                model_buf = load_val;
                wait_cycles(HALF - 1);
            end else begin
                wait_cycles(HALF);
            end
            exp_bit = (i < 32) ? w0[31 - i] : w1[31 - (i % 32)];
            miso_cap[127 - i] = sdo;
            check($sformatf("miso_bit%0d", i), 32'(sdo), 32'(exp_bit));
            sclk = 1'b1;
            wait_cycles(HALF);
            sclk = 1'b0;
        end
        wait_cycles(HALF);
        cs = 1'b1;
        sdi = 1'b0;
        wait_cycles(12);
        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        check("err_queue_drained", 32'(exp_err), 32'd0);
        $display("[TB] frame %0d bits done, rx pulses so far %0d", nbits, rx_pulses);
    endtask

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        din = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_buf = v;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, e0, b0;
        reset = 1'b1; load = 1'b0; din = '0; sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
        wait_cycles(5);
        check("reset_dout", dout, 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_nbytes", 32'(nbytes), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_sdo", 32'(sdo), 32'd0);
        reset = 1'b0;
        wait_cycles(10);

        // 32-bit word both ways
        do_load(32'hA5C3_0F96);
        p0 = rx_pulses;
        run_frame(32, {32'h1234_5678, 96'd0}, -1, '0, -1);
        check("t1_dout", last_dout, 32'h1234_5678);
        check("t1_nbytes", 32'(last_nb), 32'd4);
        check("t1_pulses", 32'(rx_pulses - p0), 32'd1);
        check("t1_miso", miso_cap[127:96], 32'hA5C3_0F96);

        // single byte
        p0 = rx_pulses; e0 = err_pulses;
        run_frame(8, {8'h9C, 120'd0}, -1, '0, -1);
        check("t2_dout", last_dout, 32'h0000_009C);
        check("t2_nbytes", 32'(last_nb), 32'd1);
        check("t2_pulses", 32'(rx_pulses - p0), 32'd1);
        check("t2_err", 32'(err_pulses - e0), 32'd0);

        // 12 bits: one byte plus dropped nibble
        p0 = rx_pulses; e0 = err_pulses; b0 = both_pulses;
        run_frame(12, {12'hABC, 116'd0}, -1, '0, -1);
        check("t3_dout", last_dout, 32'h0000_00AB);
        check("t3_err", 32'(err_pulses - e0), 32'd1);
        check("t3_same_cycle", 32'(both_pulses - b0), 32'd1);

        // 64 bits, load mid first word
        do_load(32'h0000_0001);
        p0 = rx_pulses;
        run_frame(64, {$urandom, $urandom, 64'd0}, 10, 32'hDEAD_BEEF, -1);
        check("t4_miso", miso_cap[127:96], 32'h0000_0001);
        check("t4_miso2", miso_cap[95:64], 32'hDEAD_BEEF);
        check("t4_pulses", 32'(rx_pulses - p0), 32'd2);

        // reset at bit 10 with cs held low
        p0 = rx_pulses;
        run_frame(40, {$urandom, $urandom, 64'd0}, -1, '0, 10);
        wait_cycles(5);
        check("t5_dout", dout, 32'd0);
        check("t5_nbytes", 32'(nbytes), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_sdo", 32'(sdo), 32'd0);
        for (int k = 0; k < 40; k++) begin
            sdi = 1'($urandom);
            wait_cycles(HALF);
            sclk = 1'b1;
            wait_cycles(HALF);
            sclk = 1'b0;
        end
        check("t5_busy_blocked", 32'(busy), 32'd0);
        check("t5_no_rx", 32'(rx_pulses - p0), 32'd0);
        cs = 1'b1;
        wait_cycles(10);
        run_frame(16, {16'h5A3C, 112'd0}, -1, '0, -1);
        check("t5_next_dout", last_dout, 32'h0000_5A3C);
        check("t5_next_nbytes", 32'(last_nb), 32'd2);
        check("t5_next_miso", 32'(miso_cap[127:112]), 32'd0);

        // load on the cycle the frame starts
        do_load(32'h7FFF_FFFF);
        run_frame(32, {$urandom, 96'd0}, -2, 32'h8000_0000, -1);
        check("t6_miso", miso_cap[127:96], 32'h8000_0000);
        check("t6_sdo_idle", 32'(sdo), 32'd0);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1) do_load($urandom);
            run_frame(int'($urandom_range(1, 70)), {$urandom, $urandom, $urandom, $urandom},
                      -1, '0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
